// File: rtl/nbit_logic_checker_pkg.sv
// Shared definitions for the n-bit logic checker: FSM states and mismatch-mask bit positions.
package nbit_logic_checker_pkg;

   // Checker FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Bit positions inside the 8-bit mismatch mask
   localparam int MASK_NOT  = 0;
   localparam int MASK_AND  = 1;
   localparam int MASK_OR   = 2;
   localparam int MASK_NAND = 3;
   localparam int MASK_NOR  = 4;
   localparam int MASK_XOR  = 5;
   localparam int MASK_XNOR = 6;
   localparam int MASK_SEQ  = 7;

   // Number of gate outputs compared per vector (mask bits 0..6)
   localparam int NUM_GATES = 7;

endpackage

// File: rtl/nbit_logic_checker_if.sv
// Vector bus between a gate-array stimulus/response source and the checker.
interface nbit_logic_checker_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [WIDTH-1:0] not_out;
   logic [WIDTH-1:0] and_out;
   logic [WIDTH-1:0] or_out;
   logic [WIDTH-1:0] nand_out;
   logic [WIDTH-1:0] nor_out;
   logic [WIDTH-1:0] xor_out;
   logic [WIDTH-1:0] xnor_out;

   // Source side: offers operands plus observed gate results
   modport master (
      output in_valid, in1, in2, not_out, and_out, or_out,
             nand_out, nor_out, xor_out, xnor_out,
      input  in_ready
   );

   // Checker side: consumes vectors, applies back-pressure through in_ready
   modport slave (
      input  in_valid, in1, in2, not_out, and_out, or_out,
             nand_out, nor_out, xor_out, xnor_out,
      output in_ready
   );
endinterface

// File: rtl/nbit_logic_checker_gate_ref.sv
// Combinational golden model of the seven two-input gate functions, bit-sliced.
module nbit_gate_ref #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_in1,
   input  logic [WIDTH-1:0] i_in2,
   output logic [WIDTH-1:0] o_not,
   output logic [WIDTH-1:0] o_and,
   output logic [WIDTH-1:0] o_or,
   output logic [WIDTH-1:0] o_nand,
   output logic [WIDTH-1:0] o_nor,
   output logic [WIDTH-1:0] o_xor,
   output logic [WIDTH-1:0] o_xnor
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign o_not[gi]  = ~i_in1[gi];
         assign o_and[gi]  = i_in1[gi] & i_in2[gi];
         assign o_or[gi]   = i_in1[gi] | i_in2[gi];
         assign o_nand[gi] = ~(i_in1[gi] & i_in2[gi]);
         assign o_nor[gi]  = ~(i_in1[gi] | i_in2[gi]);
         assign o_xor[gi]  = i_in1[gi] ^ i_in2[gi];
         assign o_xnor[gi] = ~(i_in1[gi] ^ i_in2[gi]);
      end
   endgenerate

endmodule

// File: rtl/nbit_logic_checker.sv
// Self-checker for an exhaustive n-bit gate sweep: verifies gate results and
// vector ordering, counts vectors/errors and captures the first failure.
module nbit_logic_checker
   import nbit_logic_checker_pkg::*;
#(
   parameter int WIDTH   = 4,
   // Derived values; leave at their defaults
   parameter int NUM_VEC = 2 ** (2 * WIDTH),
   parameter int CNT_W   = 2 * WIDTH + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   nbit_logic_checker_if.slave  vec_if,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CNT_W-1:0]     vec_count,
   output logic [CNT_W-1:0]     err_count,
   output logic [CNT_W-1:0]     first_err_idx,
   output logic [7:0]           first_err_mask,
   output logic [WIDTH-1:0]     first_err_in1,
   output logic [WIDTH-1:0]     first_err_in2
);

   localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_VEC - 1);

   state_t r_state;
   state_t w_state_next;

   logic w_in_ready;
   logic w_accept;
   logic w_enter_run;

   // Stage 1 registers
   logic             r_s1_valid;
   logic [CNT_W-1:0] r_exp_idx;
   logic [CNT_W-1:0] r_s1_idx;
   logic [WIDTH-1:0] r_s1_in1;
   logic [WIDTH-1:0] r_s1_in2;
   logic [WIDTH-1:0] r_s1_obs [NUM_GATES];

   // Stage 2 / result registers
   logic             r_s2_valid;
   logic [CNT_W-1:0] r_vec_count;
   logic [CNT_W-1:0] r_err_count;
   logic [CNT_W-1:0] r_first_idx;
   logic [7:0]       r_first_mask;
   logic [WIDTH-1:0] r_first_in1;
   logic [WIDTH-1:0] r_first_in2;
   logic             r_pass;

   // Expected gate results and mismatch mask
   logic [WIDTH-1:0] w_exp [NUM_GATES];
   logic [7:0]       w_mask;

   assign w_accept    = vec_if.in_valid && w_in_ready;
   assign w_enter_run = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state logic; RUN ends on the NUM_VEC-th acceptance, DRAIN waits for an empty pipe
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_state_next = ST_RUN;
         ST_RUN:   if (w_accept && (r_exp_idx == LAST_IDX)) w_state_next = ST_DRAIN;
         ST_DRAIN: if (!r_s1_valid && !r_s2_valid) w_state_next = ST_DONE;
         ST_DONE:  if (start) w_state_next = ST_RUN;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // FSM outputs decoded from the current state only
   always_comb begin
      w_in_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_in_ready = 1'b1;
            busy       = 1'b1;
         end
         ST_DRAIN: busy = 1'b1;
         ST_DONE:  done = 1'b1;
         default: begin
            w_in_ready = 1'b0;
         end
      endcase
   end

   assign vec_if.in_ready = w_in_ready;

   // Stage 1: capture accepted vector with its expected sweep index, then advance the index
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_exp_idx  <= '0;
         r_s1_idx   <= '0;
         r_s1_in1   <= '0;
         r_s1_in2   <= '0;
         for (int i = 0; i < NUM_GATES; i++) begin
            r_s1_obs[i] <= '0;
         end
      end else begin
         r_s1_valid <= w_accept;
         if (w_enter_run) begin
            r_exp_idx <= '0;
         end else if (w_accept) begin
            r_s1_idx            <= r_exp_idx;
            r_exp_idx           <= r_exp_idx + CNT_W'(1);
            r_s1_in1            <= vec_if.in1;
            r_s1_in2            <= vec_if.in2;
            r_s1_obs[MASK_NOT]  <= vec_if.not_out;
            r_s1_obs[MASK_AND]  <= vec_if.and_out;
            r_s1_obs[MASK_OR]   <= vec_if.or_out;
            r_s1_obs[MASK_NAND] <= vec_if.nand_out;
            r_s1_obs[MASK_NOR]  <= vec_if.nor_out;
            r_s1_obs[MASK_XOR]  <= vec_if.xor_out;
            r_s1_obs[MASK_XNOR] <= vec_if.xnor_out;
         end
      end
   end

   nbit_gate_ref #(
      .WIDTH (WIDTH)
   ) u_gate_ref (
      .i_in1  (r_s1_in1),
      .i_in2  (r_s1_in2),
      .o_not  (w_exp[MASK_NOT]),
      .o_and  (w_exp[MASK_AND]),
      .o_or   (w_exp[MASK_OR]),
      .o_nand (w_exp[MASK_NAND]),
      .o_nor  (w_exp[MASK_NOR]),
      .o_xor  (w_exp[MASK_XOR]),
      .o_xnor (w_exp[MASK_XNOR])
   );

   // One mask bit per gate: any differing bit in that gate's output flags it
   genvar gi;
   generate
      for (gi = 0; gi < NUM_GATES; gi++) begin : g_mask
         assign w_mask[gi] = (r_s1_obs[gi] != w_exp[gi]);
      end
   endgenerate

   // Ordering is judged against the expected index, so one skip taints all later vectors
   assign w_mask[MASK_SEQ] = ({r_s1_in1, r_s1_in2} != r_s1_idx[2*WIDTH-1:0]);

   // Stage 2: fold the mask into the counters and latch the first failure only
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid   <= 1'b0;
         r_vec_count  <= '0;
         r_err_count  <= '0;
         r_first_idx  <= '0;
         r_first_mask <= '0;
         r_first_in1  <= '0;
         r_first_in2  <= '0;
      end else begin
         r_s2_valid <= r_s1_valid;
         if (w_enter_run) begin
            r_vec_count  <= '0;
            r_err_count  <= '0;
            r_first_idx  <= '0;
            r_first_mask <= '0;
            r_first_in1  <= '0;
            r_first_in2  <= '0;
         end else if (r_s1_valid) begin
            if (r_vec_count != NUM_VEC_C) begin
               r_vec_count <= r_vec_count + CNT_W'(1);
            end
            if (w_mask != 8'h00) begin
               if (r_err_count != '1) begin
                  r_err_count <= r_err_count + CNT_W'(1);
               end
               if (r_err_count == '0) begin
                  r_first_idx  <= r_s1_idx;
                  r_first_mask <= w_mask;
                  r_first_in1  <= r_s1_in1;
                  r_first_in2  <= r_s1_in2;
               end
            end
         end
      end
   end

   // Verdict is sampled once, on the DRAIN->DONE transition, when the counters are final
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pass <= 1'b0;
      end else if (w_enter_run) begin
         r_pass <= 1'b0;
      end else if ((r_state == ST_DRAIN) && (w_state_next == ST_DONE)) begin
         r_pass <= (r_err_count == '0) && (r_vec_count == NUM_VEC_C);
      end
   end

   assign pass           = r_pass;
   assign vec_count      = r_vec_count;
   assign err_count      = r_err_count;
   assign first_err_idx  = r_first_idx;
   assign first_err_mask = r_first_mask;
   assign first_err_in1  = r_first_in1;
   assign first_err_in2  = r_first_in2;

endmodule

// File: tb/tb_nbit_logic_checker.sv
// Bench for nbit_logic_checker: table of sweep scenarios with spec-derived results,
// a reset-abort sequence, and a random-fault sweep scored by a behavioural model.
module tb_nbit_logic_checker;

   localparam int WIDTH   = 4;
   localparam int NUM_VEC = 256;
   localparam int CNT_W   = 9;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] vec_count;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] first_err_idx;
   logic [7:0]       first_err_mask;
   logic [WIDTH-1:0] first_err_in1;
   logic [WIDTH-1:0] first_err_in2;

   nbit_logic_checker_if #(.WIDTH(WIDTH)) vif ();

   nbit_logic_checker #(.WIDTH(WIDTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .vec_if         (vif),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .vec_count      (vec_count),
      .err_count      (err_count),
      .first_err_idx  (first_err_idx),
      .first_err_mask (first_err_mask),
      .first_err_in1  (first_err_in1),
      .first_err_in2  (first_err_in2)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Fault list for the current sweep: vector value, gate number (0..6), xor pattern
   int         flt_idx [$];
   int         flt_op  [$];
   logic [3:0] flt_flip[$];

   // Behavioural reference results
   int         m_vec;
   int         m_err;
   int         m_first_idx;
   logic [7:0] m_first_mask;
   int         m_first_in1;
   int         m_first_in2;

   typedef struct {
      int         gap;
      bit         skip;
      bit         junk;
      int         fi0;
      int         fo0;
      logic [3:0] ff0;
      int         fi1;
      int         fo1;
      logic [3:0] ff1;
      int         e_vec;
      int         e_err;
      int         e_idx;
      logic [7:0] e_mask;
      int         e_in1;
      int         e_in2;
      bit         e_pass;
   } row_t;

   row_t rows [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic logic [3:0] gate(input int op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         0:       return ~a;
         1:       return a & b;
         2:       return a | b;
         3:       return ~(a & b);
         4:       return ~(a | b);
         5:       return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   // k-th vector to send: in order, or with vector 1 skipped (wrapping to 0 at the end)
   function automatic int vec_of(input bit skip, input int k);
      if (!skip) return k;
      return (k == 0) ? 0 : (k + 1) % NUM_VEC;
   endfunction

   task automatic model_clear();
      m_vec        = 0;
      m_err        = 0;
      m_first_idx  = 0;
      m_first_mask = 8'h00;
      m_first_in1  = 0;
      m_first_in2  = 0;
   endtask

   // Score the k-th accepted vector directly from the gate truth and sweep-order rules
   task automatic model_accept(input int k, input logic [3:0] a, input logic [3:0] b,
                               input logic [6:0][3:0] obs);
      logic [7:0] mask;
      mask = 8'h00;
      for (int op = 0; op < 7; op++) begin
         if (obs[op] != gate(op, a, b)) mask[op] = 1'b1;
      end
      if (int'(a) * 16 + int'(b) != k) mask[7] = 1'b1;
      if (m_vec < NUM_VEC) m_vec++;
      if (mask != 8'h00) begin
         if (m_err == 0) begin
            m_first_idx  = k;
            m_first_mask = mask;
            m_first_in1  = int'(a);
            m_first_in2  = int'(b);
         end
         if (m_err < 511) m_err++;
      end
   endtask

   task automatic drive_vec(input logic [3:0] a, input logic [3:0] b, input logic [6:0][3:0] obs);
      vif.in1      = a;
      vif.in2      = b;
      vif.not_out  = obs[0];
      vif.and_out  = obs[1];
      vif.or_out   = obs[2];
      vif.nand_out = obs[3];
      vif.nor_out  = obs[4];
      vif.xor_out  = obs[5];
      vif.xnor_out = obs[6];
   endtask

   function automatic logic [6:0][3:0] observed(input int v);
      logic [6:0][3:0] obs;
      logic [7:0]      vv;
      vv = v[7:0];
      for (int op = 0; op < 7; op++) obs[op] = gate(op, vv[7:4], vv[3:0]);
      foreach (flt_idx[j]) begin
         if (flt_idx[j] == v) obs[flt_op[j]] = obs[flt_op[j]] ^ flt_flip[j];
      end
      return obs;
   endfunction

   // One sweep: optional idle junk, start pulse, NUM_VEC vectors (random gaps), drain to DONE.
   // abort_after >= 0 stops sending after that many accepted vectors and returns mid-sweep.
   task automatic run_sweep(input int gap_pct, input bit skip, input bit junk, input int abort_after);
      int              k;
      int              cyc;
      int              v;
      bit              acc;
      logic [3:0]      a;
      logic [3:0]      b;
      logic [6:0][3:0] obs;
      model_clear();
      if (junk) begin
         for (int i = 0; i < 5; i++) begin
            v = int'($urandom_range(0, NUM_VEC - 1));
            drive_vec(v[7:4], v[3:0], observed(v));
            vif.in_valid = 1'b1;
            chk("in_ready_idle", vif.in_ready, 1'b0);
            tick();
         end
         vif.in_valid = 1'b0;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      chk("done_after_start", done, 1'b0);
      chk("vec_cleared", vec_count, 0);
      chk("err_cleared", err_count, 0);
      chk("mask_cleared", first_err_mask, 8'h00);
      k   = 0;
      cyc = 0;
      while (k < NUM_VEC && k != abort_after) begin
         acc = 1'b0;
         if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            vif.in_valid = 1'b0;
         end else begin
            v   = vec_of(skip, k);
            a   = v[7:4];
            b   = v[3:0];
            obs = observed(v);
            drive_vec(a, b, obs);
            vif.in_valid = 1'b1;
            chk("in_ready_run", vif.in_ready, 1'b1);
            acc = 1'b1;
         end
         tick();
         if (acc) begin
            model_accept(k, a, b, obs);
            k++;
         end
         cyc++;
         if (cyc > 4 * NUM_VEC) begin
            chk("sweep_timeout", k, NUM_VEC);
            break;
         end
      end
      vif.in_valid = 1'b0;
      if (k == abort_after) return;
      // Keep offering junk during DRAIN/DONE; it must be dropped
      v = int'($urandom_range(0, NUM_VEC - 1));
      drive_vec(v[7:4], v[3:0], observed(v));
      vif.in_valid = 1'b1;
      chk("in_ready_drain", vif.in_ready, 1'b0);
      chk("busy_drain", busy, 1'b1);
      for (int i = 0; i < 10 && !done; i++) tick();
      chk("done_reached", done, 1'b1);
      chk("busy_done", busy, 1'b0);
      chk("in_ready_done", vif.in_ready, 1'b0);
      tick();
      vif.in_valid = 1'b0;
   endtask

   task automatic run_row(input int r);
      flt_idx.delete();
      flt_op.delete();
      flt_flip.delete();
      if (rows[r].fi0 >= 0) begin
         flt_idx.push_back(rows[r].fi0); flt_op.push_back(rows[r].fo0); flt_flip.push_back(rows[r].ff0);
      end
      if (rows[r].fi1 >= 0) begin
         flt_idx.push_back(rows[r].fi1); flt_op.push_back(rows[r].fo1); flt_flip.push_back(rows[r].ff1);
      end
      run_sweep(rows[r].gap, rows[r].skip, rows[r].junk, -1);
      chk($sformatf("row%0d_vec_count", r), vec_count, rows[r].e_vec);
      chk($sformatf("row%0d_err_count", r), err_count, rows[r].e_err);
      chk($sformatf("row%0d_first_idx", r), first_err_idx, rows[r].e_idx);
      chk($sformatf("row%0d_first_mask", r), first_err_mask, rows[r].e_mask);
      chk($sformatf("row%0d_first_in1", r), first_err_in1, rows[r].e_in1);
      chk($sformatf("row%0d_first_in2", r), first_err_in2, rows[r].e_in2);
      chk($sformatf("row%0d_pass", r), pass, rows[r].e_pass);
      $display("row %0d: vec=%0d err=%0d idx=%0d mask=%02h pass=%0d", r, vec_count, err_count,
               first_err_idx, first_err_mask, pass);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"}, vif.in_ready, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_pass"}, pass, 1'b0);
      chk({tag, "_vec_count"}, vec_count, 0);
      chk({tag, "_err_count"}, err_count, 0);
      chk({tag, "_first_idx"}, first_err_idx, 0);
      chk({tag, "_first_mask"}, first_err_mask, 8'h00);
      chk({tag, "_first_in1"}, first_err_in1, 0);
      chk({tag, "_first_in2"}, first_err_in2, 0);
   endtask

   initial begin
      //          gap skp jnk fi0 fo0 ff0   fi1  fo1 ff1   vec  err  idx mask   in1 in2 pass
      rows[0] = '{0,  0,  0,  -1, 0,  4'h0, -1,  0,  4'h0, 256, 0,   0,  8'h00, 0,  0,  1};
      rows[1] = '{0,  0,  0,  53, 1,  4'h1, -1,  0,  4'h0, 256, 1,   53, 8'h02, 3,  5,  0};
      rows[2] = '{0,  1,  0,  -1, 0,  4'h0, -1,  0,  4'h0, 256, 255, 1,  8'h80, 0,  2,  0};
      rows[3] = '{50, 0,  1,  -1, 0,  4'h0, -1,  0,  4'h0, 256, 0,   0,  8'h00, 0,  0,  1};
      rows[4] = '{0,  0,  0,  10, 5,  4'hF, 200, 0,  4'h3, 256, 2,   10, 8'h20, 0,  10, 0};
      rows[5] = '{25, 0,  0,  -1, 0,  4'h0, -1,  0,  4'h0, 256, 0,   0,  8'h00, 0,  0,  1};

      rst   = 1'b1;
      start = 1'b0;
      vif.in_valid = 1'b0;
      drive_vec(4'h0, 4'h0, '0);
      repeat (3) tick();
      chk_all_zero("reset");
      rst = 1'b0;
      tick();

      for (int r = 0; r < 3; r++) run_row(r);

      // Reset mid-sweep after 100 accepted vectors; everything must clear
      flt_idx.delete(); flt_op.delete(); flt_flip.delete();
      run_sweep(0, 1'b0, 1'b0, 100);
      chk("abort_busy_before_rst", busy, 1'b1);
      rst = 1'b1;
      tick();
      chk_all_zero("abort");
      $display("abort: reset after 100 vectors, vec=%0d busy=%0d", vec_count, busy);
      rst = 1'b0;
      tick();

      for (int r = 3; r < 6; r++) run_row(r);

      // Random faults, scored only by the behavioural model
      flt_idx.delete(); flt_op.delete(); flt_flip.delete();
      for (int j = 0; j < 3; j++) begin
         flt_idx.push_back(int'($urandom_range(0, NUM_VEC - 1)));
         flt_op.push_back(int'($urandom_range(0, 6)));
         flt_flip.push_back(4'($urandom_range(1, 15)));
      end
      run_sweep(30, 1'b0, 1'b0, -1);
      chk("rand_vec_count", vec_count, m_vec);
      chk("rand_err_count", err_count, m_err);
      chk("rand_first_idx", first_err_idx, m_first_idx);
      chk("rand_first_mask", first_err_mask, m_first_mask);
      chk("rand_first_in1", first_err_in1, m_first_in1);
      chk("rand_first_in2", first_err_in2, m_first_in2);
      chk("rand_pass", pass, (m_err == 0) && (m_vec == NUM_VEC));
      $display("random: vec=%0d err=%0d idx=%0d mask=%02h pass=%0d", vec_count, err_count,
               first_err_idx, first_err_mask, pass);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
